// File: rtl/axis_framer_pkg.sv
// Shared definitions for the AXI-Stream packet framer: FSM encoding and
// header/trailer field positions.
package axis_framer_pkg;

  localparam int unsigned STATE_WIDTH = 2;
  localparam int unsigned SEQ_WIDTH   = 16;
  localparam int unsigned MAGIC_WIDTH = 16;

  localparam int unsigned MAGIC_LSB = 16;
  localparam int unsigned SEQ_LSB   = 0;
  localparam int unsigned OVF_BIT   = 31;

  typedef enum logic [STATE_WIDTH-1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    TRAILER = 2'd2
  } framer_state_t;

endpackage

// File: rtl/axis_pipe_reg.sv
// One-stage AXI-Stream output register. A beat is captured on load while the
// slot is free and is held unchanged for as long as downstream stalls.
module axis_pipe_reg #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  axis_aclk,
  input  logic                  axis_areset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_tdata,
  input  logic                  load_tlast,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic                  out_free_c
);

  assign out_free_c = ~m_axis_tvalid | m_axis_tready;

  // Load wins over drain; an unconsumed beat is never overwritten.
  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
    end else if (load && out_free_c) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tlast  <= load_tlast;
      m_axis_tdata  <= load_tdata;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_packet_framer.sv
// Wraps each combined AXI-Stream packet in a header beat {magic, seq} and a
// trailer beat {overflow, word count} so the host can detect lost/short packets.
module axis_packet_framer
  import axis_framer_pkg::*;
#(
  parameter int unsigned          AXIS_TDATA_WIDTH = 32,
  parameter logic [MAGIC_WIDTH-1:0] HEADER_MAGIC   = 16'hA55A,
  parameter int unsigned          CNT_WIDTH        = 16
) (
  input  logic                        axis_aclk,
  input  logic                        axis_areset,
  output logic                        s_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic                        s_axis_tlast,
  input  logic                        m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast,
  output logic [SEQ_WIDTH-1:0]        seq_out,
  output logic                        busy
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  framer_state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]          cnt_q;
  logic                          ovf_q;
  logic [SEQ_WIDTH-1:0]          seq_q;

  logic                          out_free_c;
  logic                          load_c;
  logic [AXIS_TDATA_WIDTH-1:0]   load_tdata_c;
  logic                          load_tlast_c;
  logic                          cnt_clr_c;
  logic                          cnt_inc_c;
  logic                          seq_inc_c;

  axis_pipe_reg #(
    .DATA_WIDTH (AXIS_TDATA_WIDTH)
  ) u_out_reg (
    .axis_aclk     (axis_aclk),
    .axis_areset   (axis_areset),
    .load          (load_c),
    .load_tdata    (load_tdata_c),
    .load_tlast    (load_tlast_c),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .out_free_c    (out_free_c)
  );

  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      state_q <= IDLE;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != IDLE);
    end
  end

  // Next state, beat mux and the side effects of each load.
  always_comb begin
    state_d       = state_q;
    s_axis_tready = 1'b0;
    load_c        = 1'b0;
    load_tdata_c  = '0;
    load_tlast_c  = 1'b0;
    cnt_clr_c     = 1'b0;
    cnt_inc_c     = 1'b0;
    seq_inc_c     = 1'b0;

    unique case (state_q)
      IDLE: begin
        // The waiting input word only triggers the header; it is taken next.
        if (s_axis_tvalid && out_free_c) begin
          load_c                                = 1'b1;
          load_tdata_c[MAGIC_LSB +: MAGIC_WIDTH] = HEADER_MAGIC;
          load_tdata_c[SEQ_LSB +: SEQ_WIDTH]     = seq_q;
          cnt_clr_c                             = 1'b1;
          state_d                               = PAYLOAD;
        end
      end
      PAYLOAD: begin
        s_axis_tready = out_free_c;
        if (s_axis_tvalid && out_free_c) begin
          load_c       = 1'b1;
          load_tdata_c = s_axis_tdata;
          cnt_inc_c    = 1'b1;
          if (s_axis_tlast) begin
            state_d = TRAILER;
          end
        end
      end
      TRAILER: begin
        if (out_free_c) begin
          load_c                       = 1'b1;
          load_tdata_c[CNT_WIDTH-1:0]  = cnt_q;
          load_tdata_c[OVF_BIT]        = ovf_q;
          load_tlast_c                 = 1'b1;
          seq_inc_c                    = 1'b1;
          state_d                      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Saturating payload counter; overflow is sticky until the next header.
  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (cnt_clr_c) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (cnt_inc_c) begin
      if (cnt_q == CNT_MAX) begin
        ovf_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      seq_q <= '0;
    end else if (seq_inc_c) begin
      seq_q <= seq_q + SEQ_WIDTH'(1);
    end
  end

  assign seq_out = seq_q;

endmodule

// File: tb/tb_axis_packet_framer.sv
// Directed self-checking bench for axis_packet_framer: framing, stalls,
// counter saturation (narrow counter instance) and mid-frame reset.
module tb_axis_packet_framer;

  localparam int unsigned W = 32;

  logic         axis_aclk   = 1'b0;
  logic         axis_areset = 1'b1;
  logic [W-1:0] s_tdata     = '0;
  logic         s_tvalid    = 1'b0;
  logic         s_tlast     = 1'b0;
  logic         m_tready    = 1'b1;
  logic         sel         = 1'b0;

  logic         s_tready0, mv0, ml0, busy0;
  logic [W-1:0] md0;
  logic [15:0]  seq0;
  logic         s_tready4, mv4, ml4, busy4;
  logic [W-1:0] md4;
  logic [15:0]  seq4;

  logic         s_tvalid0, s_tvalid4;
  logic         s_tready_sel, mv, ml;
  logic [W-1:0] md;

  int           vectors    = 0;
  int           miscompares = 0;
  int           stall_err  = 0;
  int           rdy_mode   = 0;
  logic [32:0]  beats[$];
  logic [32:0]  exp[$];
  logic         held_v = 1'b0;
  logic         held_l = 1'b0;
  logic [W-1:0] held_d = '0;

  assign s_tvalid0    = s_tvalid & ~sel;
  assign s_tvalid4    = s_tvalid & sel;
  assign s_tready_sel = sel ? s_tready4 : s_tready0;
  assign mv           = sel ? mv4 : mv0;
  assign ml           = sel ? ml4 : ml0;
  assign md           = sel ? md4 : md0;

  axis_packet_framer #(.AXIS_TDATA_WIDTH(W), .HEADER_MAGIC(16'hA55A), .CNT_WIDTH(16)) dut (
    .axis_aclk(axis_aclk), .axis_areset(axis_areset),
    .s_axis_tready(s_tready0), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid0),
    .s_axis_tlast(s_tlast), .m_axis_tready(m_tready), .m_axis_tdata(md0),
    .m_axis_tvalid(mv0), .m_axis_tlast(ml0), .seq_out(seq0), .busy(busy0));

  axis_packet_framer #(.AXIS_TDATA_WIDTH(W), .HEADER_MAGIC(16'hA55A), .CNT_WIDTH(4)) dut4 (
    .axis_aclk(axis_aclk), .axis_areset(axis_areset),
    .s_axis_tready(s_tready4), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid4),
    .s_axis_tlast(s_tlast), .m_axis_tready(m_tready), .m_axis_tdata(md4),
    .m_axis_tvalid(mv4), .m_axis_tlast(ml4), .seq_out(seq4), .busy(busy4));

  always #5 axis_aclk = ~axis_aclk;

  // Output monitor: collects delivered beats and watches the hold/stall rules.
  always @(negedge axis_aclk) begin
    if (axis_areset) begin
      held_v = 1'b0;
    end else begin
      if (held_v && (mv !== 1'b1 || md !== held_d || ml !== held_l)) stall_err++;
      if (mv && !m_tready && s_tready_sel) stall_err++;
      held_v = mv && !m_tready;
      held_d = md;
      held_l = ml;
      if (mv && m_tready) beats.push_back({ml, md});
    end
  end

  function automatic logic [32:0] hdr(input logic [15:0] s);
    return {1'b0, 16'hA55A, s};
  endfunction

  function automatic logic [32:0] pay(input int v);
    return {1'b0, 32'(v)};
  endfunction

  function automatic logic [32:0] trl(input logic ovf, input int c);
    return {1'b1, ovf, 31'(c)};
  endfunction

  task automatic step();
    @(posedge axis_aclk);
    #1;
    if (rdy_mode == 1) m_tready = ~m_tready;
    else               m_tready = 1'b1;
  endtask

  task automatic send_words(input int base, input int n, input bit last, input bit rnd);
    int  i = 0;
    int  guard = 0;
    logic acc;
    while (i < n) begin
      s_tvalid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      s_tdata  = 32'(base + i);
      s_tlast  = last && (i == n - 1);
      @(negedge axis_aclk);
      acc = s_tvalid && s_tready_sel;
      step();
      if (acc) i++;
      guard++;
      if (guard > 2000) begin
        miscompares++;
        $display("FAIL send_timeout got %0d words want %0d", i, n);
        break;
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_beats(input int n);
    int g = 0;
    while (beats.size() < n && g < 500) begin
      step();
      g++;
    end
    repeat (4) step();
  endtask

  task automatic do_reset();
    axis_areset = 1'b1;
    s_tvalid    = 1'b0;
    s_tlast     = 1'b0;
    rdy_mode    = 0;
    m_tready    = 1'b1;
    step();
    step();
    axis_areset = 1'b0;
    step();
    beats.delete();
    exp.delete();
  endtask

  task automatic test_reset();
    axis_areset = 1'b1;
    #1;
    vectors++; if (mv0 !== 1'b0)   begin miscompares++; $display("FAIL rst_tvalid got %b want 0", mv0); end
    vectors++; if (ml0 !== 1'b0)   begin miscompares++; $display("FAIL rst_tlast got %b want 0", ml0); end
    vectors++; if (md0 !== '0)     begin miscompares++; $display("FAIL rst_tdata got %h want 0", md0); end
    vectors++; if (s_tready0 !== 1'b0) begin miscompares++; $display("FAIL rst_tready got %b want 0", s_tready0); end
    vectors++; if (seq0 !== 16'h0) begin miscompares++; $display("FAIL rst_seq got %h want 0", seq0); end
    vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b want 0", busy0); end
    vectors++; if (mv4 !== 1'b0)   begin miscompares++; $display("FAIL rst_tvalid4 got %b want 0", mv4); end
    do_reset();
  endtask

  task automatic test_basic();
    do_reset();
    send_words(1, 4, 1'b1, 1'b0);
    wait_beats(6);
    exp.push_back(hdr(16'h0));
    for (int k = 1; k <= 4; k++) exp.push_back(pay(k));
    exp.push_back(trl(1'b0, 4));
    vectors++;
    if (beats.size() !== exp.size()) begin miscompares++; $display("FAIL basic_count got %0d want %0d", beats.size(), exp.size()); end
    for (int k = 0; k < exp.size() && k < beats.size(); k++) begin
      vectors++;
      if (beats[k] !== exp[k]) begin miscompares++; $display("FAIL basic_beat%0d got %h want %h", k, beats[k], exp[k]); end
    end
    vectors++; if (seq0 !== 16'h1) begin miscompares++; $display("FAIL basic_seq got %h want 1", seq0); end
    vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("FAIL basic_busy got %b want 0", busy0); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_words(11, 3, 1'b1, 1'b0);
    send_words(21, 3, 1'b1, 1'b0);
    wait_beats(10);
    exp.push_back(hdr(16'h0));
    for (int k = 0; k < 3; k++) exp.push_back(pay(11 + k));
    exp.push_back(trl(1'b0, 3));
    exp.push_back(hdr(16'h1));
    for (int k = 0; k < 3; k++) exp.push_back(pay(21 + k));
    exp.push_back(trl(1'b0, 3));
    vectors++;
    if (beats.size() !== exp.size()) begin miscompares++; $display("FAIL b2b_count got %0d want %0d", beats.size(), exp.size()); end
    for (int k = 0; k < exp.size() && k < beats.size(); k++) begin
      vectors++;
      if (beats[k] !== exp[k]) begin miscompares++; $display("FAIL b2b_beat%0d got %h want %h", k, beats[k], exp[k]); end
    end
    vectors++; if (seq0 !== 16'h2) begin miscompares++; $display("FAIL b2b_seq got %h want 2", seq0); end
  endtask

  task automatic test_stall();
    do_reset();
    stall_err = 0;
    rdy_mode  = 1;
    send_words(41, 4, 1'b1, 1'b1);
    wait_beats(6);
    rdy_mode  = 0;
    step();
    exp.push_back(hdr(16'h0));
    for (int k = 0; k < 4; k++) exp.push_back(pay(41 + k));
    exp.push_back(trl(1'b0, 4));
    vectors++;
    if (beats.size() !== exp.size()) begin miscompares++; $display("FAIL stall_count got %0d want %0d", beats.size(), exp.size()); end
    for (int k = 0; k < exp.size() && k < beats.size(); k++) begin
      vectors++;
      if (beats[k] !== exp[k]) begin miscompares++; $display("FAIL stall_beat%0d got %h want %h", k, beats[k], exp[k]); end
    end
    vectors++;
    if (stall_err !== 0) begin miscompares++; $display("FAIL stall_hold got %0d violations want 0", stall_err); end
  endtask

  task automatic test_single_word();
    do_reset();
    send_words(32'h77, 1, 1'b1, 1'b0);
    wait_beats(3);
    exp.push_back(hdr(16'h0));
    exp.push_back(pay(32'h77));
    exp.push_back(trl(1'b0, 1));
    vectors++;
    if (beats.size() !== exp.size()) begin miscompares++; $display("FAIL single_count got %0d want %0d", beats.size(), exp.size()); end
    for (int k = 0; k < exp.size() && k < beats.size(); k++) begin
      vectors++;
      if (beats[k] !== exp[k]) begin miscompares++; $display("FAIL single_beat%0d got %h want %h", k, beats[k], exp[k]); end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    sel = 1'b1;
    send_words(1, 18, 1'b1, 1'b0);
    wait_beats(20);
    exp.push_back(hdr(16'h0));
    for (int k = 1; k <= 18; k++) exp.push_back(pay(k));
    exp.push_back({1'b1, 32'h8000000F});
    vectors++;
    if (beats.size() !== exp.size()) begin miscompares++; $display("FAIL ovf_count got %0d want %0d", beats.size(), exp.size()); end
    for (int k = 0; k < exp.size() && k < beats.size(); k++) begin
      vectors++;
      if (beats[k] !== exp[k]) begin miscompares++; $display("FAIL ovf_beat%0d got %h want %h", k, beats[k], exp[k]); end
    end
    beats.delete();
    exp.delete();
    send_words(100, 1, 1'b1, 1'b0);
    wait_beats(3);
    exp.push_back(hdr(16'h1));
    exp.push_back(pay(100));
    exp.push_back(trl(1'b0, 1));
    vectors++;
    if (beats.size() !== exp.size()) begin miscompares++; $display("FAIL ovf_next_count got %0d want %0d", beats.size(), exp.size()); end
    for (int k = 0; k < exp.size() && k < beats.size(); k++) begin
      vectors++;
      if (beats[k] !== exp[k]) begin miscompares++; $display("FAIL ovf_next_beat%0d got %h want %h", k, beats[k], exp[k]); end
    end
    sel = 1'b0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    send_words(1, 2, 1'b0, 1'b0);
    step();
    exp.push_back(hdr(16'h0));
    exp.push_back(pay(1));
    exp.push_back(pay(2));
    vectors++;
    if (beats.size() !== exp.size()) begin miscompares++; $display("FAIL mid_pre_count got %0d want %0d", beats.size(), exp.size()); end
    for (int k = 0; k < exp.size() && k < beats.size(); k++) begin
      vectors++;
      if (beats[k] !== exp[k]) begin miscompares++; $display("FAIL mid_pre_beat%0d got %h want %h", k, beats[k], exp[k]); end
    end
    vectors++; if (busy0 !== 1'b1) begin miscompares++; $display("FAIL mid_busy_before got %b want 1", busy0); end
    axis_areset = 1'b1;
    #1;
    vectors++; if (mv0 !== 1'b0)   begin miscompares++; $display("FAIL mid_rst_tvalid got %b want 0", mv0); end
    vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("FAIL mid_rst_busy got %b want 0", busy0); end
    vectors++; if (seq0 !== 16'h0) begin miscompares++; $display("FAIL mid_rst_seq got %h want 0", seq0); end
    step();
    axis_areset = 1'b0;
    step();
    beats.delete();
    exp.delete();
    send_words(3, 3, 1'b1, 1'b0);
    wait_beats(5);
    exp.push_back(hdr(16'h0));
    for (int k = 3; k <= 5; k++) exp.push_back(pay(k));
    exp.push_back(trl(1'b0, 3));
    vectors++;
    if (beats.size() !== exp.size()) begin miscompares++; $display("FAIL mid_post_count got %0d want %0d", beats.size(), exp.size()); end
    for (int k = 0; k < exp.size() && k < beats.size(); k++) begin
      vectors++;
      if (beats[k] !== exp[k]) begin miscompares++; $display("FAIL mid_post_beat%0d got %h want %h", k, beats[k], exp[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_single_word();
    test_overflow();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
